// File: rtl/fullchip_seq_ctrl_pkg.sv
// Shared definitions for the fullchip sequencer: inst bit map, field widths, FSM encoding.
// Optional readback state RDBK is used only when FULLCHIP_SEQ_READBACK_EN is defined.
package fullchip_seq_ctrl_pkg;

  localparam int INST_W     = 19;
  localparam int QK_ADD_W   = 4;
  localparam int P_ADD_W    = 4;
  localparam int CNT_W      = 8;
  localparam int SFP_PHASES = 6;

  localparam int INST_SFP_DIV    = 18;
  localparam int INST_SFP_ACC    = 17;
  localparam int INST_OFIFO_RD   = 16;
  localparam int INST_QK_ADD_LSB = 12;
  localparam int INST_P_ADD_LSB  = 8;
  localparam int INST_EXECUTE    = 7;
  localparam int INST_LOAD       = 6;
  localparam int INST_QMEM_RD    = 5;
  localparam int INST_QMEM_WR    = 4;
  localparam int INST_KMEM_RD    = 3;
  localparam int INST_KMEM_WR    = 2;
  localparam int INST_PMEM_RD    = 1;
  localparam int INST_PMEM_WR    = 0;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_QWR   = 4'd1,
    ST_KWR   = 4'd2,
    ST_LOAD  = 4'd3,
    ST_LGAP  = 4'd4,
    ST_EXEC  = 4'd5,
    ST_DGAP  = 4'd6,
    ST_OFIFO = 4'd7,
    ST_SFP   = 4'd8,
    ST_RDBK  = 4'd9
  } seq_state_e;

  function automatic logic [INST_W-1:0] qk_field(input logic [QK_ADD_W-1:0] a);
    qk_field = '0;
    qk_field[INST_QK_ADD_LSB +: QK_ADD_W] = a;
  endfunction

  function automatic logic [INST_W-1:0] p_field(input logic [P_ADD_W-1:0] a);
    p_field = '0;
    p_field[INST_P_ADD_LSB +: P_ADD_W] = a;
  endfunction

endpackage

// File: rtl/fullchip_seq_ctrl_sfp_row_seq.sv
// Six-phase per-row counter for the SFP normalize step; runs while go is high,
// restarts at phase 0 whenever go drops.
module fullchip_sfp_row_seq
  import fullchip_seq_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  go,
  output logic [SFP_PHASES-1:0] phase,
  output logic                  row_done
);

  localparam logic [2:0] PH_LAST = 3'(SFP_PHASES - 1);

  logic [2:0] ph_q, ph_d;

  always_comb begin
    ph_d = ph_q + 3'd1;
    if (!go || ph_q == PH_LAST) ph_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ph_q <= '0;
    else        ph_q <= ph_d;
  end

  for (genvar gi = 0; gi < SFP_PHASES; gi++) begin : g_phase
    assign phase[gi] = go && (ph_q == 3'(gi));
  end

  assign row_done = phase[SFP_PHASES-1];

endmodule

// File: rtl/fullchip_seq_ctrl.sv
// Attention-pass sequencer: host Q/K fill, K load, execute, ofifo drain, per-row SFP normalize.
// Define FULLCHIP_SEQ_READBACK_EN to add a pmem readback phase and the rd_valid output.
module fullchip_seq_ctrl
  import fullchip_seq_ctrl_pkg::*;
#(
  parameter int total_cycle = 8,
  parameter int col         = 8,
  parameter int pr          = 8,
  parameter int bw          = 8,
  parameter int load_gap    = 10,
  parameter int drain_gap   = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               in_valid,
  input  logic [pr*bw-1:0]   in_data,
  output logic               in_ready,
  output logic [INST_W-1:0]  inst,
  output logic [pr*bw-1:0]   mem_out,
  output logic               busy,
  output logic               done
`ifdef FULLCHIP_SEQ_READBACK_EN
  ,
  output logic               rd_valid
`endif
);

  // 4-bit address fields must not wrap inside a pass
  if (total_cycle > 16 || col > 16 || total_cycle < 1 || col < 1) begin : g_param_check
    $error("fullchip_seq_ctrl: total_cycle and col must be in 1..16");
  end

  localparam logic [CNT_W-1:0]    Q_LAST    = CNT_W'(total_cycle - 1);
  localparam logic [CNT_W-1:0]    K_LAST    = CNT_W'(col - 1);
  localparam logic [CNT_W-1:0]    KRD_LAST  = CNT_W'(col);
  localparam logic [CNT_W-1:0]    LOAD_LAST = CNT_W'(col + 1);
  localparam logic [CNT_W-1:0]    LGAP_LAST = CNT_W'(load_gap - 1);
  localparam logic [CNT_W-1:0]    DGAP_LAST = CNT_W'(drain_gap - 1);
  localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]    CNT_TWO   = CNT_W'(2);
  localparam logic [P_ADD_W-1:0]  ROW_LAST  = P_ADD_W'(total_cycle - 1);
  localparam logic [P_ADD_W-1:0]  ROW_ONE   = P_ADD_W'(1);
  localparam logic [QK_ADD_W-1:0] QK_ONE    = QK_ADD_W'(1);

  seq_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [P_ADD_W-1:0]    row_q, row_d;
  logic [INST_W-1:0]     inst_q, inst_d;
  logic [pr*bw-1:0]      mem_out_q, mem_out_d;
  logic [SFP_PHASES-1:0] sfp_phase;
  logic                  sfp_row_done;
  logic                  sfp_go;
  logic                  accept;
  logic                  last_row;
  logic [QK_ADD_W-1:0]   cnt_qk;
  logic [P_ADD_W-1:0]    cnt_p;

  assign in_ready = (state_q == ST_QWR) || (state_q == ST_KWR);
  assign busy     = (state_q != ST_IDLE);
  assign accept   = in_valid && in_ready;
  assign sfp_go   = (state_q == ST_SFP);
  assign last_row = (row_q == ROW_LAST);
  assign cnt_qk   = cnt_q[QK_ADD_W-1:0];
  assign cnt_p    = cnt_q[P_ADD_W-1:0];
  assign inst     = inst_q;
  assign mem_out  = mem_out_q;

  fullchip_sfp_row_seq u_sfp_row_seq (
    .clk      (clk),
    .reset    (reset),
    .go       (sfp_go),
    .phase    (sfp_phase),
    .row_done (sfp_row_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      row_q     <= '0;
      inst_q    <= '0;
      mem_out_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      row_q     <= row_d;
      inst_q    <= inst_d;
      mem_out_q <= mem_out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    unique case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_QWR;
        cnt_d   = '0;
      end
      ST_QWR: if (accept) begin
        if (cnt_q == Q_LAST) begin
          state_d = ST_KWR;
          cnt_d   = '0;
        end else cnt_d = cnt_q + CNT_ONE;
      end
      ST_KWR: if (accept) begin
        if (cnt_q == K_LAST) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end else cnt_d = cnt_q + CNT_ONE;
      end
      ST_LOAD: if (cnt_q == LOAD_LAST) begin
        state_d = ST_LGAP;
        cnt_d   = '0;
      end else cnt_d = cnt_q + CNT_ONE;
      ST_LGAP: if (cnt_q == LGAP_LAST) begin
        state_d = ST_EXEC;
        cnt_d   = '0;
      end else cnt_d = cnt_q + CNT_ONE;
      ST_EXEC: if (cnt_q == Q_LAST) begin
        state_d = ST_DGAP;
        cnt_d   = '0;
      end else cnt_d = cnt_q + CNT_ONE;
      ST_DGAP: if (cnt_q == DGAP_LAST) begin
        state_d = ST_OFIFO;
        cnt_d   = '0;
      end else cnt_d = cnt_q + CNT_ONE;
      ST_OFIFO: if (cnt_q == Q_LAST) begin
        state_d = ST_SFP;
        cnt_d   = '0;
        row_d   = '0;
      end else cnt_d = cnt_q + CNT_ONE;
      ST_SFP: if (sfp_row_done) begin
        if (last_row) begin
`ifdef FULLCHIP_SEQ_READBACK_EN
          state_d = ST_RDBK;
`else
          state_d = ST_IDLE;
`endif
          cnt_d = '0;
          row_d = '0;
        end else row_d = row_q + ROW_ONE;
      end
`ifdef FULLCHIP_SEQ_READBACK_EN
      ST_RDBK: if (cnt_q == Q_LAST) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else cnt_d = cnt_q + CNT_ONE;
`endif
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        row_d   = '0;
      end
    endcase
  end

  // inst is a registered function of the current state, so it trails the state by one cycle
  always_comb begin
    inst_d    = '0;
    mem_out_d = mem_out_q;
    unique case (state_q)
      ST_QWR: if (accept) begin
        inst_d               = qk_field(cnt_qk);
        inst_d[INST_QMEM_WR] = 1'b1;
        mem_out_d            = in_data;
      end
      ST_KWR: if (accept) begin
        inst_d               = qk_field(cnt_qk);
        inst_d[INST_KMEM_WR] = 1'b1;
        mem_out_d            = in_data;
      end
      ST_LOAD: begin
        if (cnt_q >= CNT_TWO && cnt_q <= KRD_LAST) inst_d = qk_field(cnt_qk - QK_ONE);
        inst_d[INST_LOAD]    = 1'b1;
        inst_d[INST_KMEM_RD] = (cnt_q != '0) && (cnt_q <= KRD_LAST);
      end
      ST_EXEC: begin
        inst_d               = qk_field(cnt_qk);
        inst_d[INST_EXECUTE] = 1'b1;
        inst_d[INST_QMEM_RD] = 1'b1;
      end
      ST_OFIFO: begin
        inst_d                = p_field(cnt_p);
        inst_d[INST_OFIFO_RD] = 1'b1;
        inst_d[INST_PMEM_WR]  = 1'b1;
      end
      ST_SFP: begin
        if (!sfp_phase[5]) inst_d = p_field(row_q);
        inst_d[INST_PMEM_RD] = |sfp_phase[3:0];
        inst_d[INST_SFP_ACC] = sfp_phase[1];
        inst_d[INST_SFP_DIV] = |sfp_phase[4:2];
        inst_d[INST_PMEM_WR] = sfp_phase[4];
      end
`ifdef FULLCHIP_SEQ_READBACK_EN
      ST_RDBK: begin
        inst_d               = p_field(cnt_p);
        inst_d[INST_PMEM_RD] = 1'b1;
      end
`endif
      default: ;
    endcase
  end

`ifdef FULLCHIP_SEQ_READBACK_EN
  // fullchip out is valid two cycles after the pmem_rd inst word it answers
  logic [2:0] rd_pipe_q, rd_pipe_d;
  logic [2:0] last_pipe_q, last_pipe_d;

  assign rd_pipe_d   = {rd_pipe_q[1:0], state_q == ST_RDBK};
  assign last_pipe_d = {last_pipe_q[1:0], (state_q == ST_RDBK) && (cnt_q == Q_LAST)};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_pipe_q   <= '0;
      last_pipe_q <= '0;
    end else begin
      rd_pipe_q   <= rd_pipe_d;
      last_pipe_q <= last_pipe_d;
    end
  end

  assign rd_valid = rd_pipe_q[2];
  assign done     = last_pipe_q[2];
`else
  logic done_q, done_d;

  assign done_d = sfp_go && sfp_row_done && last_row;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) done_q <= 1'b0;
    else        done_q <= done_d;
  end

  assign done = done_q;
`endif

endmodule
